// File: rtl/freq_gen_if.sv
// Configuration and waveform bundle for the programmable square-wave source.
// master: drives enable/freq_req/load, observes status and waveform.
// slave : the generator; drives busy/cfg_err/half_period/wave_out/edge_strb.
interface freq_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             enable;
    logic [WIDTH-1:0] freq_req;
    logic             load;
    logic             busy;
    logic             cfg_err;
    logic [WIDTH-1:0] half_period;
    logic             wave_out;
    logic             edge_strb;

    modport master (
        output enable, freq_req, load,
        input  busy, cfg_err, half_period, wave_out, edge_strb
    );

    modport slave (
        input  enable, freq_req, load,
        output busy, cfg_err, half_period, wave_out, edge_strb
    );
endinterface

// File: rtl/freq_generator.sv
// Programmable square-wave source.
// A requested frequency (Hz) is range-checked and turned into a half-period
// in clk cycles by a bit-serial restoring divider (CLK_HZ / (2*freq_req)).
// A phase counter then toggles wave_out every half_period cycles; a new
// half-period is only adopted at a toggle boundary so phases never glitch.
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   bus.enable  1 = run the waveform, 0 = hold wave_out low
//   bus.freq_req/bus.load  request, captured on a load strobe when idle
//   bus.busy    check/divide in progress (loads ignored)
//   bus.cfg_err last request rejected (zero or above CLK_HZ/2)
//   bus.half_period committed half-period in clk cycles
//   bus.wave_out/bus.edge_strb  waveform and its rising-edge pulse
module freq_generator #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned WIDTH  = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    freq_gen_if.slave bus
);

    localparam int unsigned DW = WIDTH + 1;      // divisor / remainder width
    localparam int unsigned RW = WIDTH + 2;      // shifted remainder width
    localparam int unsigned SW = $clog2(WIDTH);  // divide step counter width

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;

    // Configuration FSM and divider state
    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] freq_q,    freq_d;
    logic [DW-1:0]    den_q,     den_d;
    logic [DW-1:0]    rem_q,     rem_d;
    logic [WIDTH-1:0] quo_q,     quo_d;
    logic [SW-1:0]    step_q,    step_d;
    logic             busy_q,    busy_d;
    logic             cfg_err_q, cfg_err_d;
    logic [WIDTH-1:0] half_q,    half_d;

    // Waveform generator state
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] active_q;
    logic             wave_q;
    logic             strb_q;

    // Divider datapath
    logic [DW-1:0] den_c;
    logic [RW-1:0] rem_shift_c;
    logic [RW-1:0] rem_sub_c;
    logic          take_c;

    // Waveform control
    logic             running_c;
    logic [WIDTH-1:0] last_c;

    // 2*freq_req computed one bit wider so it can never overflow
    assign den_c       = {freq_q, 1'b0};
    // Restoring step: bring the next dividend bit into the remainder
    assign rem_shift_c = {rem_q, quo_q[WIDTH-1]};
    assign take_c      = (rem_shift_c >= {1'b0, den_q});
    assign rem_sub_c   = rem_shift_c - {1'b0, den_q};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            freq_q    <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            step_q    <= '0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            half_q    <= '0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
            half_q    <= half_d;
        end
    end

    // FSM next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        den_d     = den_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        step_d    = step_q;
        cfg_err_d = cfg_err_q;
        half_d    = half_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    freq_d  = bus.freq_req;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((freq_q == '0) || (den_c > DW'(CLK_HZ))) begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cfg_err_d = 1'b0;
                    den_d     = den_c;
                    rem_d     = '0;
                    quo_d     = WIDTH'(CLK_HZ);
                    step_d    = '0;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d  = take_c ? DW'(rem_sub_c) : DW'(rem_shift_c);
                quo_d  = {quo_q[WIDTH-2:0], take_c};
                step_d = step_q + SW'(1);
                if (step_q == SW'(WIDTH - 1)) begin
                    half_d  = {quo_q[WIDTH-2:0], take_c};
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign running_c = bus.enable && (active_q != '0);
    assign last_c    = active_q - WIDTH'(1);

    // Phase counter; half_d is used so a commit coinciding with a toggle
    // is picked up on that same toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            active_q <= '0;
            wave_q   <= 1'b0;
            strb_q   <= 1'b0;
        end else if (!running_c) begin
            count_q  <= '0;
            active_q <= half_d;
            wave_q   <= 1'b0;
            strb_q   <= 1'b0;
        end else if (count_q == last_c) begin
            count_q  <= '0;
            active_q <= half_d;
            wave_q   <= ~wave_q;
            strb_q   <= ~wave_q;
        end else begin
            count_q  <= count_q + WIDTH'(1);
            strb_q   <= 1'b0;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.half_period = half_q;
    assign bus.wave_out    = wave_q;
    assign bus.edge_strb   = strb_q;

endmodule

// File: doc/freq_generator.md
Name: freq_generator

Overview:
- Programmable square-wave source: the transmit-side counterpart of the frequency counter.
- Software requests a frequency in Hz; a sequential divider converts it to a half-period in clk cycles.
- A counter then toggles wave_out at that rate.
- Used to drive the counter's signal input for loopback self-test, and as a general tone/clock source.

Parameters:
- CLK_HZ, 100000000, frequency of clk in Hz (numerator of the division).
- WIDTH, 32, width of freq_req and half_period.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = generate waveform; 0 = hold wave_out low.
- freq_req  input  WIDTH  requested output frequency in Hz; sampled on load.
- load  input  1  one-cycle strobe to start a new configuration.
- busy  output  1  divider running; load is ignored while high.
- cfg_err  output  1  last load was rejected (freq_req out of range).
- half_period  output  WIDTH  committed half-period in clk cycles.
- wave_out  output  1  generated square wave (registered).
- edge_strb  output  1  one-cycle pulse on the same edge wave_out goes 0->1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). Asserting rst_n=0 immediately forces:
  - wave_out=0, edge_strb=0, busy=0, cfg_err=0, half_period=0;
  - config FSM to IDLE, internal counter=0, active_half=0.
  - Reset mid-divide aborts the divide; nothing is committed.
- Config FSM states: IDLE, CHECK, DIV.
- IDLE:
  - On load=1, capture freq_req and go to CHECK; busy=1 from the next cycle.
  - load while busy=1 is ignored (no capture, no restart).
- CHECK (1 cycle):
  - Compute den = 2*freq_req in WIDTH+1 bits (no overflow).
  - If freq_req==0 or den > CLK_HZ: set cfg_err=1, leave half_period unchanged, return to IDLE.
  - Otherwise clear cfg_err and go to DIV.
- DIV:
  - Restoring divider, one quotient bit per cycle, WIDTH cycles.
  - Computes q = floor(CLK_HZ/den).
  - On the final cycle, commit half_period=q and return to IDLE.
- Busy timing:
  - Valid request: busy is high for exactly WIDTH+1 cycles (33 by default), load edge +1 through +33.
  - Rejected request: busy is high for 1 cycle.
- Guaranteed range: a valid request always yields q>=1.
- Wave generator:
  - When enable=0 or active_half==0: counter=0, wave_out=0, edge_strb=0 (registered, takes effect the next edge).
  - Start-up: when the generator is idle (enable=0 or active_half==0), active_half is loaded from half_period every cycle.
  - Running (enable=1, active_half!=0): counter increments each cycle.
  - When counter==active_half-1: counter<=0, wave_out toggles, active_half<=half_period.
  - Each phase is therefore exactly active_half cycles; output frequency = CLK_HZ/(2*active_half).
  - First rising edge occurs active_half cycles after enable is seen high.
- Glitch-free reconfiguration:
  - A new half_period takes effect only at a toggle boundary; the phase in progress completes at the old length.
  - No high or low phase is ever shorter than min(old,new).
- edge_strb: 1 exactly in the cycle where wave_out has just become 1; never high two consecutive cycles unless active_half==1.
- Simultaneous events:
  - The commit and a toggle may occur on the same edge; the toggle then loads the new value.
  - enable falling on a toggle edge: wave_out=0 wins.

Test Plan:
- Reset/idle: hold rst_n=0, then release with enable=1 and no load -> all outputs 0, wave_out stays 0 for 200 cycles.
- Basic config: freq_req=1000000, pulse load -> busy high 33 cycles, half_period=50; wave_out period 100 cycles at 50% duty, edge_strb every 100 cycles.
- Truncation and extremes:
  - freq_req=3000000 -> half_period=16 (period 32).
  - freq_req=50000000 -> half_period=1, wave_out toggles every cycle, edge_strb every 2 cycles.
  - freq_req=1 -> half_period=50000000.
- Rejection:
  - freq_req=0 -> cfg_err=1 after 1 busy cycle, half_period keeps previous 50.
  - freq_req=50000001 -> cfg_err=1.
  - A following valid load clears cfg_err.
- Reprogram mid-wave: running at 50, load 2000000 mid-phase -> current phase finishes at 50 cycles, subsequent phases are 25; a second load during busy is ignored (half_period ends at 25).
- Abort paths:
  - Drop enable mid-phase -> wave_out=0 next edge, counter cleared; re-enable -> first rise after half_period cycles.
  - Assert rst_n=0 at divide cycle 10 -> busy=0, half_period=0 immediately, no later commit.
